sti_rx: RTL and testbench

Serial-to-parallel receiver for the STI serial link. It reconstructs 16-bit words from the serial bit stream (serial data + valid), using the same per-frame framing controls as the transmitter: length, bit order, fill position and low-byte select. It sits on the receive end of the link, feeding a word-wide consumer. It also reports padding errors, counts frames and flags end-of-stream.

---
 rtl/sti_rx.sv | 191 +++++++++++++++++++
 tb/tb_sti_rx.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sti_rx.sv
// sti_rx: STI serial link receiver, rebuilds 16-bit words from a framed
// serial stream with per-frame length, bit order, fill and byte select.
//
// Ports:
//   clk, reset                 rising-edge clock, async active-low reset
//   cfg_load/cfg_*             frame setup, accepted while cfg_ready=1
//   si_data, si_valid          serial bit and its qualifier
//   cfg_ready                  receiver idle, can take a frame setup
//   po_data, po_valid          reconstructed word and its one-cycle strobe
//   pad_err                    a padding bit of the delivered frame was 1
//   frame_cnt                  completed frames, wraps 255->0
//   rx_done                    sticky, last frame of the stream delivered
module sti_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_load,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        cfg_fill,
    input  logic        cfg_low,
    input  logic        cfg_end,
    input  logic        si_data,
    input  logic        si_valid,
    output logic        cfg_ready,
    output logic [15:0] po_data,
    output logic        po_valid,
    output logic        pad_err,
    output logic [7:0]  frame_cnt,
    output logic        rx_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  len_q, len_d;
    logic        msb_q, msb_d;
    logic        fill_q, fill_d;
    logic        low_q, low_d;
    logic        end_q, end_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] frm_q, frm_d;
    logic [15:0] po_data_q, po_data_d;
    logic        po_valid_q, po_valid_d;
    logic        pad_err_q, pad_err_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic [4:0]  last_idx;
    logic [4:0]  bit_idx;
    logic [31:0] frm_nxt;
    logic [15:0] word;
    logic        pad;

    // Frame length minus one: 7, 15, 23 or 31.
    assign last_idx = {len_q, 3'b111};

    // MSB-first fills the frame from its top bit downward.
    assign bit_idx = msb_q ? (last_idx - cnt_q) : cnt_q;

    // Frame register including the bit arriving this cycle, so the
    // final bit is part of the extracted word.
    always_comb begin
        frm_nxt = frm_q;
        frm_nxt[bit_idx] = si_data;
    end

    always_comb begin
        word = 16'h0000;
        pad  = 1'b0;
        unique case (len_q)
            2'd0: begin
                word = low_q ? {frm_nxt[7:0], 8'h00}
                             : {8'h00, frm_nxt[7:0]};
            end
            2'd1: begin
                word = frm_nxt[15:0];
            end
            2'd2: begin
                if (fill_q) begin
                    word = frm_nxt[23:8];
                    pad  = |frm_nxt[7:0];
                end else begin
                    word = frm_nxt[15:0];
                    pad  = |frm_nxt[23:16];
                end
            end
            2'd3: begin
                if (fill_q) begin
                    word = frm_nxt[31:16];
                    pad  = |frm_nxt[15:0];
                end else begin
                    word = frm_nxt[15:0];
                    pad  = |frm_nxt[31:16];
                end
            end
            default: begin
                word = 16'h0000;
                pad  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        msb_d       = msb_q;
        fill_d      = fill_q;
        low_d       = low_q;
        end_d       = end_q;
        cnt_d       = cnt_q;
        frm_d       = frm_q;
        po_data_d   = po_data_q;
        po_valid_d  = 1'b0;
        pad_err_d   = pad_err_q;
        frame_cnt_d = frame_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_load) begin
                    len_d   = cfg_length;
                    msb_d   = cfg_msb;
                    fill_d  = cfg_fill;
                    low_d   = cfg_low;
                    end_d   = cfg_end;
                    cnt_d   = 5'd0;
                    frm_d   = 32'h0;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (si_valid) begin
                    frm_d = frm_nxt;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == last_idx) begin
                        po_data_d   = word;
                        pad_err_d   = pad;
                        po_valid_d  = 1'b1;
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = end_q ? S_DONE : S_IDLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= 2'd0;
            msb_q       <= 1'b0;
            fill_q      <= 1'b0;
            low_q       <= 1'b0;
            end_q       <= 1'b0;
            cnt_q       <= 5'd0;
            frm_q       <= 32'h0;
            po_data_q   <= 16'h0000;
            po_valid_q  <= 1'b0;
            pad_err_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            msb_q       <= msb_d;
            fill_q      <= fill_d;
            low_q       <= low_d;
            end_q       <= end_d;
            cnt_q       <= cnt_d;
            frm_q       <= frm_d;
            po_data_q   <= po_data_d;
            po_valid_q  <= po_valid_d;
            pad_err_q   <= pad_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign cfg_ready = (state_q == S_IDLE);
    assign rx_done   = (state_q == S_DONE);
    assign po_data   = po_data_q;
    assign po_valid  = po_valid_q;
    assign pad_err   = pad_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sti_rx.sv
// tb_sti_rx: directed bench for sti_rx, frames driven bit by bit with
// hand-computed words, padding flags and frame counts.
module tb_sti_rx;

    logic        clk;
    logic        reset;
    logic        cfg_load;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        cfg_fill;
    logic        cfg_low;
    logic        cfg_end;
    logic        si_data;
    logic        si_valid;
    logic        cfg_ready;
    logic [15:0] po_data;
    logic        po_valid;
    logic        pad_err;
    logic [7:0]  frame_cnt;
    logic        rx_done;

    int          errors;
    int          checks;
    logic [7:0]  exp_cnt;

    sti_rx dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_load  (cfg_load),
        .cfg_length(cfg_length),
        .cfg_msb   (cfg_msb),
        .cfg_fill  (cfg_fill),
        .cfg_low   (cfg_low),
        .cfg_end   (cfg_end),
        .si_data   (si_data),
        .si_valid  (si_valid),
        .cfg_ready (cfg_ready),
        .po_data   (po_data),
        .po_valid  (po_valid),
        .pad_err   (pad_err),
        .frame_cnt (frame_cnt),
        .rx_done   (rx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, {31'd0, cfg_ready}, 32'd1);
        chk({tag, "_data"}, {16'd0, po_data}, 32'h0);
        chk({tag, "_valid"}, {31'd0, po_valid}, 32'd0);
        chk({tag, "_pad"}, {31'd0, pad_err}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, frame_cnt}, 32'd0);
        chk({tag, "_done"}, {31'd0, rx_done}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_cnt = 8'd0;
    endtask

    // Called at a negedge; loads the frame, shifts it in and checks the
    // delivered word at the negedge after the last sampling edge.
    task automatic send(input logic [1:0] len, input logic msb,
                        input logic fill, input logic low,
                        input logic fin, input logic [31:0] data,
                        input logic [15:0] exp_po, input logic exp_pad,
                        input int ga, input int gla,
                        input int gb, input int glb,
                        input logic load_valid);
        int nbits;
        nbits      = 8 * (int'(len) + 1);
        cfg_length = len;
        cfg_msb    = msb;
        cfg_fill   = fill;
        cfg_low    = low;
        cfg_end    = fin;
        cfg_load   = 1'b1;
        si_valid   = load_valid;
        si_data    = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        si_valid = 1'b0;
        chk("valid_one_cycle", {31'd0, po_valid}, 32'd0);
        chk("ready_busy", {31'd0, cfg_ready}, 32'd0);
        for (int i = 0; i < nbits; i++) begin
            si_valid = 1'b1;
            si_data  = msb ? data[nbits-1-i] : data[i];
            if (i == nbits - 1)
                chk("valid_early", {31'd0, po_valid}, 32'd0);
            @(negedge clk);
            if (i == ga || i == gb) begin
                si_valid = 1'b0;
                si_data  = ~si_data;
                repeat ((i == ga) ? gla : glb) @(negedge clk);
                chk("gap_hold", {31'd0, po_valid}, 32'd0);
            end
        end
        si_valid = 1'b0;
        exp_cnt  = exp_cnt + 8'd1;
        chk("po_valid", {31'd0, po_valid}, 32'd1);
        chk("po_data", {16'd0, po_data}, {16'd0, exp_po});
        chk("pad_err", {31'd0, pad_err}, {31'd0, exp_pad});
        chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, exp_cnt});
        chk("ready_after", {31'd0, cfg_ready}, {31'd0, ~fin});
        chk("done_after", {31'd0, rx_done}, {31'd0, fin});
    endtask

    initial begin
        logic [7:0]  b;
        logic [15:0] w;
        errors     = 0;
        checks     = 0;
        exp_cnt    = 8'd0;
        reset      = 1'b1;
        cfg_load   = 1'b0;
        cfg_length = 2'd0;
        cfg_msb    = 1'b0;
        cfg_fill   = 1'b0;
        cfg_low    = 1'b0;
        cfg_end    = 1'b0;
        si_data    = 1'b0;
        si_valid   = 1'b0;
        #3;
        do_reset();

        send(2'd1, 1, 0, 0, 0, 32'h0000A5C3, 16'hA5C3, 0, -1, 0, -1, 0, 0);
        send(2'd0, 0, 0, 1, 0, 32'h0000003C, 16'h3C00, 0, -1, 0, -1, 0, 0);
        send(2'd0, 0, 0, 0, 0, 32'h0000003C, 16'h003C, 0, -1, 0, -1, 0, 0);
        send(2'd3, 1, 1, 0, 0, 32'h12340000, 16'h1234, 0, -1, 0, -1, 0, 0);
        send(2'd3, 1, 1, 0, 0, 32'h12340001, 16'h1234, 1, -1, 0, -1, 0, 0);
        send(2'd3, 0, 0, 0, 0, 32'h80005678, 16'h5678, 1, -1, 0, -1, 0, 0);
        send(2'd2, 1, 1, 0, 0, 32'h00ABCD00, 16'hABCD, 0, -1, 0, -1, 0, 0);
        send(2'd2, 0, 0, 0, 0, 32'h0000BEEF, 16'hBEEF, 0, 5, 3, 20, 1, 0);
        send(2'd2, 1, 0, 0, 0, 32'h0001BEEF, 16'hBEEF, 1, -1, 0, -1, 0, 0);
        send(2'd0, 1, 0, 0, 0, 32'h00000096, 16'h0096, 0, -1, 0, -1, 0, 1);
        send(2'd1, 0, 0, 0, 0, 32'h00001234, 16'h1234, 0, -1, 0, -1, 0, 0);
        send(2'd1, 1, 0, 0, 1, 32'h0000C0DE, 16'hC0DE, 0, -1, 0, -1, 0, 0);

        for (int i = 0; i < 20; i++) begin
            cfg_load   = 1'b1;
            cfg_length = 2'd0;
            si_valid   = 1'b1;
            si_data    = i[0];
            @(negedge clk);
            chk("done_no_valid", {31'd0, po_valid}, 32'd0);
        end
        cfg_load = 1'b0;
        si_valid = 1'b0;
        chk("done_cnt", {24'd0, frame_cnt}, 32'd12);
        chk("done_sticky", {31'd0, rx_done}, 32'd1);
        chk("done_ready", {31'd0, cfg_ready}, 32'd0);
        chk("done_data", {16'd0, po_data}, 32'h0000C0DE);

        do_reset();
        cfg_length = 2'd1;
        cfg_msb    = 1'b1;
        cfg_end    = 1'b0;
        cfg_load   = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        for (int i = 0; i < 11; i++) begin
            si_valid = 1'b1;
            si_data  = 1'b1;
            @(negedge clk);
        end
        si_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        reset   = 1'b1;
        exp_cnt = 8'd0;
        send(2'd1, 1, 0, 0, 0, 32'h00000F0F, 16'h0F0F, 0, -1, 0, -1, 0, 0);

        do_reset();
        for (int i = 0; i < 257; i++) begin
            b = i[7:0] ^ 8'h5A;
            w = i[1] ? {b, 8'h00} : {8'h00, b};
            send(2'd0, i[0], 0, i[1], 0, {24'd0, b}, w, 0,
                 -1, 0, -1, 0, 0);
            if (i == 254)
                chk("cnt_255", {24'd0, frame_cnt}, 32'd255);
            if (i == 255)
                chk("cnt_wrap0", {24'd0, frame_cnt}, 32'd0);
        end
        chk("cnt_wrap1", {24'd0, frame_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
